vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart of the display driver.
- Samples an incoming RGB444 video stream (vsync, hsync, data-enable, 4-bit R/G/B) and writes one complete frame into the pixel frame buffer through a simple write port.
- Used for loop-back test of the display path and for camera/video ingest into the same frame RAM.
- Single-shot: software arms it, it captures exactly one frame, then reports status.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- ADDR_W, 19, frame-buffer address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)
- VS_ACTIVE, 1, vsync asserted level (1 = active high, 0 = active low)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- pix_en_i  in  1  pixel strobe; stream inputs valid only in cycles where it is 1
- vsync_i  in  1  vertical sync, polarity per VS_ACTIVE
- hsync_i  in  1  horizontal sync, informational only (sampled, not used for timing)
- de_i  in  1  data enable, 1 during active pixels
- red_i  in  4  red component
- green_i  in  4  green component
- blue_i  in  4  blue component
- start_i  in  1  one-cycle arm request
- wr_en_o  out  1  frame-buffer write strobe
- wr_addr_o  out  ADDR_W  write address, linear: y*WIDTH + x
- wr_data_o  out  12  pixel {red, green, blue}
- busy_o  out  1  capture armed or in progress
- frame_done_o  out  1  one-cycle pulse at end of capture
- line_err_o  out  1  sticky: a line had != WIDTH pixels
- frame_err_o  out  1  sticky: vsync arrived before HEIGHT lines
- lines_o  out  10  lines completed in the last or current capture

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal x/y/addr counters 0, de/vsync history registers 0 (vsync history = deasserted level).
- Sampling:
  - Stream inputs are evaluated only in cycles with pix_en_i=1.
  - Edge detection compares against the value held at the previous pix_en_i=1 cycle.
- FSM states and transitions:
  - IDLE: busy_o=0. When start_i=1, clear line_err_o, frame_err_o and lines_o, then go to ARM. start_i in any other state is ignored.
  - ARM: busy_o=1. Wait for vsync to go from deasserted to asserted, then go to SYNC. A capture never starts mid-frame.
  - SYNC: wait for vsync to go from asserted to deasserted, then go to ACTIVE with x=0, y=0, addr=0.
  - ACTIVE, strobe with de_i=1 and x<WIDTH:
    - Next cycle: wr_en_o=1, wr_addr_o=addr, wr_data_o={red_i,green_i,blue_i}.
    - Then x++ and addr++.
    - Write latency is exactly 1 clk after the sampling cycle; wr_en_o is a single-cycle pulse per pixel.
  - ACTIVE, strobe with de_i=1 and x>=WIDTH: no write, set line_err_o; addr does not advance.
  - ACTIVE, de falling edge (previous 1, current 0):
    - If x!=WIDTH, set line_err_o.
    - If x<WIDTH, addr advances by WIDTH-x so line y+1 starts at (y+1)*WIDTH.
    - Then x=0, y++, lines_o=y+1.
    - If y+1==HEIGHT, go to DONE.
  - ACTIVE, vsync asserting edge: set frame_err_o and go to DONE. A partial line is not counted.
  - DONE: frame_done_o=1 for exactly one clk, busy_o=0, then go to IDLE.
- Simultaneous events in one strobe:
  - Vsync asserting edge and de falling edge together: the de falling edge is processed first (line counted). frame_err_o is set only if lines are still short afterwards.
- Wrap-around: addr never exceeds WIDTH*HEIGHT-1, because writes are blocked once x>=WIDTH and the frame ends at HEIGHT lines.
- Reset mid-capture: immediate return to IDLE, wr_en_o drops asynchronously, no frame_done_o pulse.
- Error flags hold until the next accepted start_i or reset.

Test Plan:
- WIDTH=8, HEIGHT=4, pix_en_i every 2nd clk. Start, then a clean frame of 4 lines x 8 pixels with data = x + 16*y. Required: 32 writes at addr 0..31 carrying matching data, each 1 clk after its strobe; frame_done_o pulses once; lines_o=4; both error flags 0.
- Arm mid-frame (de toggling, vsync deasserted). Required: no writes until a full vsync pulse completes; the following frame is captured from addr 0.
- One line with 6 pixels, next line with 10 pixels. Required: line_err_o=1; the short line's successor starts at addr 16; the long line writes only 8 pixels; no addr > 31.
- Vsync asserts after 2 complete lines. Required: frame_err_o=1, lines_o=2, frame_done_o pulses, busy_o=0.
- Assert rst during line 1 with wr_en_o active. Required: all outputs 0 at once. A new start_i followed by a clean frame captures normally from addr 0.
- start_i pulsed while busy, and a second start_i after done. Required: the first is ignored; the second clears the sticky flags and re-arms (busy_o=1).

Source files
------------

// File: rtl/vga_capture.sv
// Single-shot RGB444 frame grabber: arms on request, waits for a fresh frame
// boundary, then writes one frame linearly (y*WIDTH + x) into the frame buffer.
module vga_capture #(
    parameter int   WIDTH     = 640,
    parameter int   HEIGHT    = 480,
    parameter int   ADDR_W    = 19,
    parameter logic VS_ACTIVE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en_i,
    input  logic              vsync_i,
    input  logic              hsync_i,
    input  logic              de_i,
    input  logic [3:0]        red_i,
    input  logic [3:0]        green_i,
    input  logic [3:0]        blue_i,
    input  logic              start_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [11:0]       wr_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              line_err_o,
    output logic              frame_err_o,
    output logic [9:0]        lines_o
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_ACTIVE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d, y_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              de_prev_q, de_prev_d;
    logic              vs_prev_q, vs_prev_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;
    logic [9:0]        lines_q, lines_d;
    logic              vs_now, vs_rise, vs_fall, de_fall;
    logic              unused_hsync;

    assign unused_hsync = hsync_i;

    // Sync history is kept as "asserted" regardless of polarity; edges only count on strobes.
    assign vs_now  = (vsync_i == VS_ACTIVE);
    assign vs_rise = pix_en_i & vs_now & ~vs_prev_q;
    assign vs_fall = pix_en_i & ~vs_now & vs_prev_q;
    assign de_fall = pix_en_i & ~de_i & de_prev_q;
    assign y_inc   = y_q + YW'(1);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        de_prev_d   = pix_en_i ? de_i : de_prev_q;
        vs_prev_d   = pix_en_i ? vs_now : vs_prev_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        line_err_d  = line_err_q;
        frame_err_d = frame_err_q;
        lines_d     = lines_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    line_err_d  = 1'b0;
                    frame_err_d = 1'b0;
                    lines_d     = '0;
                    state_d     = S_ARM;
                end
            end
            S_ARM: begin
                if (vs_rise) state_d = S_ARM == S_ARM ? S_SYNC : S_ARM;
            end
            S_SYNC: begin
                if (vs_fall) begin
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (pix_en_i && de_i) begin
                    if (x_q < XW'(WIDTH)) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {red_i, green_i, blue_i};
                        x_d       = x_q + XW'(1);
                        addr_d    = addr_q + ADDR_W'(1);
                    end else begin
                        line_err_d = 1'b1;
                    end
                end
                // A short line skips the unwritten tail so the next line starts on its row.
                if (de_fall) begin
                    if (x_q != XW'(WIDTH)) line_err_d = 1'b1;
                    if (x_q < XW'(WIDTH)) addr_d = addr_q + ADDR_W'(WIDTH) - ADDR_W'(x_q);
                    x_d     = '0;
                    y_d     = y_inc;
                    lines_d = 10'(y_inc);
                    if (y_inc == YW'(HEIGHT)) state_d = S_DONE;
                end
                if (vs_rise && state_d != S_DONE) begin
                    frame_err_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            de_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            lines_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            de_prev_q   <= de_prev_d;
            vs_prev_q   <= vs_prev_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            lines_q     <= lines_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign busy_o       = (state_q == S_ARM) || (state_q == S_SYNC) || (state_q == S_ACTIVE);
    assign frame_done_o = (state_q == S_DONE);
    assign line_err_o   = line_err_q;
    assign frame_err_o  = frame_err_q;
    assign lines_o      = lines_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture (8x4 frame): table-driven and randomized frames, checked
// against a line-length based frame model and a write scoreboard.
module tb_vga_capture;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          pix_en_i, vsync_i, hsync_i, de_i, start_i;
    logic [3:0]    red_i, green_i, blue_i;
    logic          wr_en_o, busy_o, frame_done_o, line_err_o, frame_err_o;
    logic [AW-1:0] wr_addr_o;
    logic [11:0]   wr_data_o;
    logic [9:0]    lines_o;

    vga_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .VS_ACTIVE(1'b1)) dut (
        .clk(clk), .rst(rst), .pix_en_i(pix_en_i), .vsync_i(vsync_i), .hsync_i(hsync_i),
        .de_i(de_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i), .start_i(start_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .line_err_o(line_err_o), .frame_err_o(frame_err_o),
        .lines_o(lines_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    typedef struct packed {
        logic [2:0]       nl;
        logic [1:0]       trail;
        logic             mid_arm;
        logic             mid_start;
        logic [3:0][3:0]  len;
        logic             le;
        logic             fe;
        logic [2:0]       lines;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    bit          sb_en = 1'b1;
    logic        pe_s;
    wr_t         exp_q[$];
    logic [11:0] pix [H][16];
    int          lens [H];
    vec_t        vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard: each write must follow a strobe edge and match the model in order.
    always @(posedge clk) begin
        pe_s = pix_en_i;
        #1;
        if (frame_done_o) done_cnt++;
        if (wr_en_o && sb_en) begin
            chk("wr_latency", 32'(pe_s), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr_o, wr_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr_data", 32'({wr_addr_o, wr_data_o}), 32'({e.addr, e.data}));
            end
        end
    end

    function automatic vec_t mk(input int nl, input int trail, input bit ma, input bit ms,
                                input int l0, input int l1, input int l2, input int l3,
                                input bit le, input bit fe, input int lines);
        vec_t v;
        v.nl = 3'(nl); v.trail = 2'(trail); v.mid_arm = ma; v.mid_start = ms;
        v.len[0] = 4'(l0); v.len[1] = 4'(l1); v.len[2] = 4'(l2); v.len[3] = 4'(l3);
        v.le = le; v.fe = fe; v.lines = 3'(lines);
        return v;
    endfunction

    task automatic strobe(input logic vs, input logic d_e, input logic [11:0] d, input logic st);
        @(negedge clk);
        pix_en_i = 1'b1; vsync_i = vs; de_i = d_e; start_i = st;
        {red_i, green_i, blue_i} = d;
        hsync_i = ~d_e;
        @(negedge clk);
        pix_en_i = 1'b0; start_i = 1'b0;
    endtask

    task automatic vs_pulse();
        strobe(1'b1, 1'b0, 12'h0, 1'b0);
        strobe(1'b1, 1'b0, 12'h0, 1'b0);
        strobe(1'b0, 1'b0, 12'h0, 1'b0);
    endtask

    // trail: 0 = nothing after last line, 1 = separate vsync pulse, 2 = vsync on the de falling strobe
    task automatic send_frame(input int nl, input int trail, input bit mid_start);
        vs_pulse();
        for (int y = 0; y < nl; y++) begin
            for (int p = 0; p < lens[y]; p++)
                strobe(1'b0, 1'b1, pix[y][p], (mid_start && y == 1 && p == 2) ? 1'b1 : 1'b0);
            if (y == nl - 1 && trail == 2) begin
                strobe(1'b1, 1'b0, 12'h0, 1'b0);
                strobe(1'b1, 1'b0, 12'h0, 1'b0);
                strobe(1'b0, 1'b0, 12'h0, 1'b0);
            end else begin
                strobe(1'b0, 1'b0, 12'h0, 1'b0);
                strobe(1'b0, 1'b0, 12'h0, 1'b0);
            end
        end
        if (trail == 1) vs_pulse();
    endtask

    // Frame model: line y lands at row y, clipped to W pixels; only completed lines count.
    task automatic build_model(input int nl, output bit le, output bit fe, output int lines);
        exp_q.delete();
        le = 1'b0;
        for (int y = 0; y < nl; y++) begin
            if (lens[y] != W) le = 1'b1;
            for (int p = 0; p < lens[y] && p < W; p++)
                exp_q.push_back('{addr: AW'(y * W + p), data: pix[y][p]});
        end
        fe = (nl < H);
        lines = nl;
    endtask

    task automatic run_capture(input int nl, input int trail, input bit mid_arm, input bit mid_start,
                               input bit le, input bit fe, input int lines);
        bit mle, mfe;
        int mlines;
        build_model(nl, mle, mfe, mlines);
        done_cnt = 0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("flags_cleared", 32'({line_err_o, frame_err_o, lines_o}), 32'd0);
        if (mid_arm) begin
            repeat (2) begin
                repeat (5) strobe(1'b0, 1'b1, 12'($urandom), 1'b0);
                repeat (2) strobe(1'b0, 1'b0, 12'h0, 1'b0);
            end
        end
        send_frame(nl, trail, mid_start);
        for (int i = 0; i < 40 && busy_o; i++) @(negedge clk);
        chk("busy_end", 32'(busy_o), 32'd0);
        chk("line_err", 32'(line_err_o), 32'(le));
        chk("frame_err", 32'(frame_err_o), 32'(fe));
        chk("lines", 32'(lines_o), 32'(lines));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("writes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit rle, rfe;
        int rl, nl, trail;
        rst = 1'b1; pix_en_i = 1'b0; vsync_i = 1'b0; hsync_i = 1'b0; de_i = 1'b0;
        start_i = 1'b0; red_i = 4'h0; green_i = 4'h0; blue_i = 4'h0;

        vecs[0] = mk(4, 0, 0, 0, 8, 8, 8, 8,  0, 0, 4);
        vecs[1] = mk(4, 0, 1, 0, 8, 8, 8, 8,  0, 0, 4);
        vecs[2] = mk(4, 0, 0, 0, 8, 6, 10, 8, 1, 0, 4);
        vecs[3] = mk(2, 1, 0, 0, 8, 8, 8, 8,  0, 1, 2);
        vecs[4] = mk(4, 2, 0, 0, 8, 8, 8, 8,  0, 0, 4);
        vecs[5] = mk(2, 2, 0, 0, 8, 8, 8, 8,  0, 1, 2);
        vecs[6] = mk(4, 0, 0, 1, 8, 8, 8, 8,  0, 0, 4);

        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({wr_en_o, busy_o, frame_done_o, line_err_o, frame_err_o,
                                  wr_addr_o, wr_data_o, lines_o}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            for (int y = 0; y < H; y++) begin
                lens[y] = int'(vecs[i].len[y]);
                for (int p = 0; p < 16; p++) pix[y][p] = 12'(p + 16 * y);
            end
            run_capture(int'(vecs[i].nl), int'(vecs[i].trail), vecs[i].mid_arm, vecs[i].mid_start,
                        vecs[i].le, vecs[i].fe, int'(vecs[i].lines));
        end

        // Reset in the middle of line 1 while a write strobe is on the bus.
        sb_en = 1'b0;
        done_cnt = 0;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        vs_pulse();
        for (int p = 0; p < W; p++) strobe(1'b0, 1'b1, 12'hABC, 1'b0);
        strobe(1'b0, 1'b0, 12'h0, 1'b0);
        strobe(1'b0, 1'b0, 12'h0, 1'b0);
        for (int p = 0; p < 3; p++) strobe(1'b0, 1'b1, 12'h5A5, 1'b0);
        chk("rst_pre_wr_en", 32'(wr_en_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_ctrl", 32'({wr_en_o, busy_o, frame_done_o, line_err_o, frame_err_o}), 32'd0);
        chk("rst_async_data", 32'({wr_addr_o, wr_data_o, lines_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        sb_en = 1'b1;
        for (int y = 0; y < H; y++) begin
            lens[y] = W;
            for (int p = 0; p < 16; p++) pix[y][p] = 12'(p + 16 * y);
        end
        run_capture(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4);

        for (int r = 0; r < 8; r++) begin
            nl = int'($urandom_range(1, H));
            trail = (nl == H) ? (($urandom % 2) ? 0 : 2) : int'($urandom_range(1, 2));
            for (int y = 0; y < H; y++) begin
                lens[y] = ($urandom % 2) ? W : int'($urandom_range(1, 12));
                for (int p = 0; p < 16; p++) pix[y][p] = 12'($urandom);
            end
            build_model(nl, rle, rfe, rl);
            run_capture(nl, trail, 1'($urandom % 2), 1'b0, rle, rfe, rl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
